// File: rtl/serv_lsu_pkg.sv
// serv_lsu_pkg: shared types and helpers for the SERV load/store sequencer.
// Contents: FSM state encoding, access-size encoding, counter terminal value,
// byte-lane select, store-data replication and load-data extension helpers.
package serv_lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    CHECK = 3'd2,
    BUS   = 3'd3,
    DONE  = 3'd4,
    TRAP  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } size_e;

  // Last counter value of the serial address phase: 32/W - 1.
  function automatic int cnt_max(input int w);
    return 32 / w - 1;
  endfunction

  // Size code 2'b11 is handled as a word access.
  function automatic size_e size_norm(input logic [1:0] sz);
    size_e res;
    case (sz)
      2'b00:   res = SIZE_B;
      2'b01:   res = SIZE_H;
      default: res = SIZE_W;
    endcase
    return res;
  endfunction

  // Byte-lane selects. The shift is evaluated at 4 bits, so lanes that
  // would land past byte 3 on an unaligned access simply fall off.
  function automatic logic [3:0] lane_sel(input size_e sz, input logic [1:0] lsb);
    logic [3:0] pat;
    case (sz)
      SIZE_B:  pat = 4'b0001;
      SIZE_H:  pat = 4'b0011;
      default: pat = 4'b1111;
    endcase
    return pat << lsb;
  endfunction

  // Store data is replicated across lanes so the slave picks it up from
  // whichever lanes sel enables.
  function automatic logic [31:0] wdat_rep(input size_e sz, input logic [31:0] wdat);
    logic [31:0] res;
    case (sz)
      SIZE_B:  res = {4{wdat[7:0]}};
      SIZE_H:  res = {2{wdat[15:0]}};
      default: res = wdat;
    endcase
    return res;
  endfunction

  // Shift the addressed lane down to bit 0, then sign/zero-extend.
  function automatic logic [31:0] load_ext(input size_e sz, input logic sgn,
                                           input logic [1:0] lsb, input logic [31:0] rdt);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdt >> {lsb, 3'b000};
    case (sz)
      SIZE_B:  res = {{24{sgn & sh[7]}}, sh[7:0]};
      SIZE_H:  res = {{16{sgn & sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/serv_lsu_cnt.sv
// serv_lsu_cnt: 5-bit serial-phase counter with synchronous clear and enable.
// Ports: clk, rst_n (async active-low), clr, en; strobes cnt0 (count 0),
// cnt1 (count 1), cnt_done (count 32/W-1). Parameter W = 1 or 4.
module serv_lsu_cnt
  import serv_lsu_pkg::*;
#(
  parameter int W = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic cnt0,
  output logic cnt1,
  output logic cnt_done
);

  localparam logic [4:0] LAST = 5'(cnt_max(W));

  logic [4:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 5'd1;
    end
  end

  assign cnt0     = (cnt == 5'd0);
  assign cnt1     = (cnt == 5'd1);
  assign cnt_done = (cnt == LAST);

endmodule

// File: rtl/serv_lsu_ctrl.sv
// serv_lsu_ctrl: SERV load/store sequencer. Drives the buffer register through
// the serial address phase, checks alignment, runs one Wishbone data cycle and
// returns aligned/extended load data with o_done or o_misalign pulses.
// Ports: i_req/i_we/i_size/i_signed/i_lsb/i_adr/i_wdat request side;
// o_bufreg_*, o_cnt* to bufreg/counter users; o_dbus_* / i_dbus_* Wishbone;
// o_rdata, o_done, o_misalign results.
// Build option: define SERV_LSU_MISALIGN_EN to trap misaligned half/word
// accesses; otherwise every access goes to the bus with truncated lanes.
module serv_lsu_ctrl
  import serv_lsu_pkg::*;
#(
  parameter int W = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_lsb,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_wdat,
  output logic        o_bufreg_en,
  output logic        o_bufreg_init,
  output logic        o_cnt0,
  output logic        o_cnt1,
  output logic        o_cnt_done,
  output logic        o_dbus_cyc,
  output logic        o_dbus_we,
  output logic [31:0] o_dbus_adr,
  output logic [3:0]  o_dbus_sel,
  output logic [31:0] o_dbus_dat,
  input  logic        i_dbus_ack,
  input  logic [31:0] i_dbus_rdt,
  output logic [31:0] o_rdata,
  output logic        o_done,
  output logic        o_misalign
);

  state_e     state;
  logic       we_q;
  logic       signed_q;
  size_e      size_q;
  logic [1:0] lsb_q;
  logic       trap_q;

  logic cnt0;
  logic cnt1;
  logic cnt_done;
  logic cnt_clr;
  logic cnt_en;
  logic misaligned;

  // Word address comes from the buffer register; the byte offset arrives
  // separately on i_lsb.
  logic unused_adr;
  assign unused_adr = ^i_adr[1:0];

  assign cnt_clr = (state == IDLE) & i_req;
  assign cnt_en  = (state == ADDR);

  serv_lsu_cnt #(
    .W (W)
  ) u_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .cnt_done (cnt_done)
  );

  // o_bufreg_en is high exactly for the ADDR phase, so it gates the strobes.
  assign o_bufreg_init = o_bufreg_en;
  assign o_cnt0        = o_bufreg_en & cnt0;
  assign o_cnt1        = o_bufreg_en & cnt1;
  assign o_cnt_done    = o_bufreg_en & cnt_done;

`ifdef SERV_LSU_MISALIGN_EN
  assign misaligned = ((size_q == SIZE_H) & i_lsb[0]) |
                      ((size_q == SIZE_W) & (|i_lsb));
`else
  // TRAP is unreachable in this build, so trap_q and o_misalign stay 0.
  assign misaligned = 1'b0;
`endif

  assign o_misalign = trap_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= SIZE_B;
      lsb_q       <= 2'b00;
      trap_q      <= 1'b0;
      o_bufreg_en <= 1'b0;
      o_dbus_cyc  <= 1'b0;
      o_dbus_we   <= 1'b0;
      o_dbus_adr  <= '0;
      o_dbus_sel  <= '0;
      o_dbus_dat  <= '0;
      o_rdata     <= '0;
      o_done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req) begin
            we_q        <= i_we;
            signed_q    <= i_signed;
            size_q      <= size_norm(i_size);
            o_bufreg_en <= 1'b1;
            state       <= ADDR;
          end
        end

        ADDR: begin
          if (cnt_done) begin
            o_bufreg_en <= 1'b0;
            state       <= CHECK;
          end
        end

        CHECK: begin
          if (misaligned) begin
            trap_q <= 1'b1;
            state  <= TRAP;
          end else begin
            // Bus signals are registered here so they hold steady until ack
            // regardless of what the buffer register does meanwhile.
            lsb_q      <= i_lsb;
            o_dbus_cyc <= 1'b1;
            o_dbus_we  <= we_q;
            o_dbus_adr <= {i_adr[31:2], 2'b00};
            o_dbus_sel <= lane_sel(size_q, i_lsb);
            o_dbus_dat <= wdat_rep(size_q, i_wdat);
            state      <= BUS;
          end
        end

        BUS: begin
          if (i_dbus_ack) begin
            o_dbus_cyc <= 1'b0;
            o_dbus_we  <= 1'b0;
            o_dbus_adr <= '0;
            o_dbus_sel <= '0;
            o_dbus_dat <= '0;
            if (!we_q) begin
              o_rdata <= load_ext(size_q, signed_q, lsb_q, i_dbus_rdt);
            end
            o_done <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end

        TRAP: begin
          trap_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
